// File: rtl/mem_store_unit_if.sv
// Store-unit handshake bundle: execute-side request,
// data-memory write port and status pulses.
interface mem_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [2:0]  req_op;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        done;
   logic        err;
   logic        busy;

   modport master (
      output req_valid, req_addr, req_data, req_op, mem_gnt,
      input  req_ready, mem_req, mem_addr, mem_wdata, mem_be,
      input  done, err, busy
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_op, mem_gnt,
      output req_ready, mem_req, mem_addr, mem_wdata, mem_be,
      output done, err, busy
   );
endinterface

// File: rtl/mem_store_unit.sv
// Store unit: aligns SB/SH/SW data into byte lanes and
// issues one or two word beats to data memory.
module mem_store_unit (
   input logic       clk,
   input logic       rst,
   mem_store_unit_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BEAT0 = 2'd1;
   localparam logic [1:0] BEAT1 = 2'd2;

   logic [1:0]  state;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        done;
   logic        err;
   logic [31:0] hi_data;
   logic [3:0]  hi_be;

   logic        op_ok;
   logic [3:0]  mask;
   logic [1:0]  off;
   logic [63:0] data64;
   logic [7:0]  be64;

   always_comb begin
      op_ok  = 1'b1;
      mask   = 4'b0000;
      off    = bus.req_addr[1:0];
      unique case (bus.req_op)
         3'b000:  mask = 4'b0001;
         3'b001:  mask = 4'b0011;
         3'b010:  mask = 4'b1111;
         default: op_ok = 1'b0;
      endcase
      be64   = {4'b0000, mask} << off;
      data64 = {32'b0, bus.req_data} << {off, 3'b000};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_be    <= 4'b0000;
         hi_data   <= 32'h0;
         hi_be     <= 4'b0000;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid && op_ok) begin
                  state     <= BEAT0;
                  mem_req   <= 1'b1;
                  mem_addr  <= {bus.req_addr[31:2], 2'b00};
                  mem_wdata <= data64[31:0];
                  mem_be    <= be64[3:0];
                  hi_data   <= data64[63:32];
                  hi_be     <= be64[7:4];
               end else if (bus.req_valid) begin
                  err <= 1'b1;
               end
            end
            BEAT0: begin
               if (bus.mem_gnt) begin
                  if (hi_be != 4'b0000) begin
                     // wraps naturally past 0xFFFFFFFC
                     state     <= BEAT1;
                     mem_addr  <= mem_addr + 32'd4;
                     mem_wdata <= hi_data;
                     mem_be    <= hi_be;
                  end else begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                     mem_be  <= 4'b0000;
                     done    <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (bus.mem_gnt) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_be  <= 4'b0000;
                  done    <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_be  <= 4'b0000;
            end
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.mem_req   = mem_req;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_be    = mem_be;
   assign bus.done      = done;
   assign bus.err       = err;
endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, and the ports SHALL be named clk and rst.
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  store request from the execute stage
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address of the store
- req_data  in  32  store data, right-aligned
- req_op  in  3  store funct3: 000 SB, 001 SH, 010 SW
- mem_req  out  1  write request to data memory
- mem_gnt  in  1  memory accepted the current beat
- mem_addr  out  32  word-aligned write address
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte enables; bit i is byte lane i
- done  out  1  one-cycle pulse when a store completes
- err  out  1  one-cycle pulse when a request is rejected
- busy  out  1  high in any state other than IDLE

Function
REQ-003 The state machine SHALL have the states IDLE, BEAT0 and BEAT1.
REQ-004 req_ready SHALL equal (state==IDLE) and SHALL be combinational from state only.
REQ-005 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_addr, req_data and req_op SHALL be captured at that edge.
REQ-006 An op other than 000, 001 or 010 SHALL NOT be accepted into BEAT0; err SHALL pulse high for exactly the next cycle, state SHALL stay IDLE, and mem_req SHALL stay 0.
REQ-007 The size mask SHALL be SB=0001, SH=0011, SW=1111, with off = req_addr[1:0].
REQ-008 be64[7:0] SHALL be mask<<off, and data64[63:0] SHALL be {32'b0, req_data}<<(8*off), computed at capture.
REQ-009 Beat0 SHALL drive mem_addr={req_addr[31:2],2'b00}, mem_wdata=data64[31:0] and mem_be=be64[3:0].
REQ-010 Beat1 SHALL be required iff be64[7:4]!=0, and SHALL drive mem_addr=beat0 address+4 (modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000), mem_wdata=data64[63:32] and mem_be=be64[7:4].
REQ-011 A valid request SHALL move state IDLE->BEAT0, and mem_req SHALL be high from the cycle after acceptance.
REQ-012 In BEAT0/BEAT1, mem_req SHALL stay high and mem_addr, mem_wdata and mem_be SHALL stay stable until mem_gnt is sampled high.
REQ-013 In BEAT0 with mem_gnt=1, state SHALL go to BEAT1 if beat1 is required, else to IDLE; in BEAT1 with mem_gnt=1, state SHALL go to IDLE.
REQ-014 On the edge that returns state to IDLE, done SHALL be set high for exactly one cycle.
REQ-015 Minimum latency SHALL be: acceptance at cycle 0 -> done at cycle 2 for an aligned store, or cycle 3 for a split store, when granted immediately.
REQ-016 When mem_req=0, mem_be SHALL be 0000; mem_addr and mem_wdata SHALL hold their last values.
REQ-017 mem_gnt SHALL be ignored while mem_req=0.
REQ-018 A new request SHALL be accepted in the same cycle that done is high, giving back-to-back stores with no bubble beyond one cycle.
REQ-019 done and err SHALL never be high in the same cycle.
REQ-020 busy SHALL equal (state!=IDLE).
REQ-021 All outputs except req_ready and busy SHALL be registered.

Reset
REQ-022 rst sampled high SHALL force state=IDLE, mem_req=0, mem_be=0000, mem_addr=0, mem_wdata=0, done=0, err=0; req_ready=1 and busy=0 SHALL follow from state=IDLE.
REQ-023 rst asserted mid-store (BEAT0 or BEAT1) SHALL abort the store: mem_req=0 in the next cycle, no done pulse, and the pending beat SHALL be dropped.
REQ-024 rst SHALL have priority over a simultaneous req_valid and mem_gnt.

Verification
REQ-025 SW, addr 0x1000, data 0xDEADBEEF, mem_gnt tied 1 -> one beat: mem_addr 0x1000, mem_wdata 0xDEADBEEF, mem_be 1111; done at cycle 2.
REQ-026 SB, addr 0x2003, data 0x000000A5 -> mem_addr 0x2000, mem_wdata 0xA5000000, mem_be 1000; single beat.
REQ-027 SW, addr 0x3002, data 0x11223344, mem_gnt delayed 3 cycles per beat -> beat0 0x3000/0x33440000/1100, beat1 0x3004/0x00001122/0011; outputs stable while waiting; exactly one done.
REQ-028 SH, addr 0xFFFFFFFF, data 0xBEEF -> beat0 0xFFFFFFFC/0xEF000000/1000, beat1 0x00000000/0x000000BE/0001.
REQ-029 req_op 011 -> err pulse for one cycle, no mem_req, req_ready stays 1; then a valid SB is accepted on the next cycle.
REQ-030 rst asserted while waiting in BEAT1 -> mem_req 0 next cycle, no done, req_ready 1; a back-to-back SW issued on the done cycle of the prior store is accepted.
